// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded ID bundle every cycle and inserts a bubble when the
// instruction in ID is squashed, is not valid, or depends on a load in EX.
// A load-use bubble holds PC and IF/ID for one cycle; a flush does not,
// because the squashed instruction must not be replayed.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [11:0] id_ctrl,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        ex_valid,
    output logic [11:0] ex_ctrl,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wreg,
    output logic        stall_if_id,
    output logic [15:0] bubble_cnt
);

    // Control word bit positions
    localparam int unsigned CTRL_ZERO_EXT  = 9;
    localparam int unsigned CTRL_REG_DST   = 8;
    localparam int unsigned CTRL_MEM_TO_RG = 6;
    localparam int unsigned CTRL_MEM_WRITE = 4;
    localparam int unsigned CTRL_BRANCH    = 3;

    logic        ex_valid_q,   ex_valid_d;
    logic [11:0] ex_ctrl_q,    ex_ctrl_d;
    logic [31:0] ex_pc4_q,     ex_pc4_d;
    logic [31:0] ex_rs_data_q, ex_rs_data_d;
    logic [31:0] ex_rt_data_q, ex_rt_data_d;
    logic [31:0] ex_imm_q,     ex_imm_d;
    logic [4:0]  ex_rs_q,      ex_rs_d;
    logic [4:0]  ex_rt_q,      ex_rt_d;
    logic [4:0]  ex_wreg_q,    ex_wreg_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic uses_rt;
    logic load_use;
    logic bubble;
    logic count_bubble;

    // Hazard detection, bubble decision and next-state bundle formation
    always_comb begin
        uses_rt = id_ctrl[CTRL_REG_DST] | id_ctrl[CTRL_MEM_WRITE] | id_ctrl[CTRL_BRANCH];

        // Only a load in EX with a non-zero destination can create the hazard;
        // once the bubble is in EX, ex_valid is low and the stall self-clears.
        load_use = ex_valid_q & ex_ctrl_q[CTRL_MEM_TO_RG] & (ex_rt_q != 5'd0) & id_valid &
                   ((ex_rt_q == id_rs) | (uses_rt & (ex_rt_q == id_rt)));

        bubble       = flush | load_use | ~id_valid;
        count_bubble = id_valid & (flush | load_use);

        ex_valid_d   = ~bubble;
        ex_ctrl_d    = bubble ? 12'd0 : id_ctrl;
        // Data fields are captured unconditionally; they are ignored downstream
        // whenever ex_valid is low.
        ex_pc4_d     = id_pc4;
        ex_rs_data_d = id_rs_data;
        ex_rt_data_d = id_rt_data;
        ex_imm_d     = {{16{~id_ctrl[CTRL_ZERO_EXT] & id_imm[15]}}, id_imm};
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_wreg_d    = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;

        bubble_cnt_d = bubble_cnt_q;
        if (count_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // EX-stage bundle and bubble counter, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= 12'd0;
            ex_pc4_q     <= 32'd0;
            ex_rs_data_q <= 32'd0;
            ex_rt_data_q <= 32'd0;
            ex_imm_q     <= 32'd0;
            ex_rs_q      <= 5'd0;
            ex_rt_q      <= 5'd0;
            ex_wreg_q    <= 5'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_wreg_q    <= ex_wreg_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Flush wins over a load-use hazard: the squashed instruction is not held.
    assign stall_if_id = load_use & ~flush;

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_wreg    = ex_wreg_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a driver applies ID stimulus and pushes the
// expected EX state and stall per cycle; a monitor pops and compares mid-cycle.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [11:0] id_ctrl;
    logic [31:0] id_pc4, id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        ex_valid;
    logic [11:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg;
    logic        stall_if_id;
    logic [15:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        bit        valid;
        bit [11:0] ctrl;
        bit [31:0] pc4, rsd, rtd;
        bit [15:0] imm;
        bit [4:0]  rs, rt, rd;
        bit        flush;
    } stim_t;

    typedef struct {
        bit        v;
        bit [11:0] ctrl;
        bit [31:0] pc4, rsd, rtd, imm;
        bit [4:0]  rs, rt, wreg;
        bit [15:0] cnt;
        bit        data_known;
    } ex_t;

    typedef struct {
        ex_t ex;
        bit  stall;
    } exp_t;

    exp_t  sb[$];
    ex_t   model;
    stim_t cur;
    bit    last_stall;
    int    checks = 0;
    int    passes = 0;

    function automatic ex_t zero_ex();
        ex_t z;
        z = '{default: 0};
        z.data_known = 1'b1;
        return z;
    endfunction

    // A consumer of a loaded register sitting right behind the load must wait.
    function automatic bit hazard(ex_t m, stim_t s);
        bit reads_rt;
        reads_rt = s.ctrl[8] || s.ctrl[4] || s.ctrl[3];
        if (!m.v || !m.ctrl[6] || m.rt == 0 || !s.valid) return 1'b0;
        return (m.rt == s.rs) || (reads_rt && m.rt == s.rt);
    endfunction

    function automatic ex_t advance(ex_t m, stim_t s);
        ex_t n;
        bit  lu, squash;
        lu     = hazard(m, s);
        squash = s.flush || lu || !s.valid;
        n.v    = !squash;
        n.ctrl = squash ? 12'd0 : s.ctrl;
        n.pc4  = s.pc4;
        n.rsd  = s.rsd;
        n.rtd  = s.rtd;
        if (!s.ctrl[9] && s.imm >= 16'd32768) n.imm = 32'hFFFF0000 + 32'(s.imm);
        else n.imm = 32'(s.imm);
        n.rs   = s.rs;
        n.rt   = s.rt;
        n.wreg = s.ctrl[8] ? s.rd : s.rt;
        n.cnt  = m.cnt;
        if (s.valid && (s.flush || lu) && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
        n.data_known = !squash;
        return n;
    endfunction

    function automatic stim_t mk(bit valid, bit [11:0] ctrl, bit [15:0] imm,
                                 bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit fl);
        stim_t s;
        s.valid = valid; s.ctrl = ctrl; s.imm = imm;
        s.rs = rs; s.rt = rt; s.rd = rd; s.flush = fl;
        s.pc4 = $urandom; s.rsd = $urandom; s.rtd = $urandom;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = mk($urandom_range(0, 99) < 85, 12'($urandom), 16'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), $urandom_range(0, 99) < 10);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.valid; id_ctrl = s.ctrl; id_pc4 = s.pc4;
        id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; flush = s.flush;
    endtask

    // One cycle: account for the edge just taken, drive new ID inputs,
    // optionally drop reset mid-cycle, and queue what the DUT must show.
    task automatic drive_cycle(input stim_t s, input bit rst_mid);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) model = advance(model, cur);
        else       model = zero_ex();
        cur = s;
        apply(s);
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            model = zero_ex();
        end
        e.ex    = model;
        e.stall = rst_n && hazard(model, s) && !s.flush;
        last_stall = e.stall;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare the queued expectation in the middle of each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stall_if_id", 32'(stall_if_id), 32'(e.stall));
                chk("ex_valid",    32'(ex_valid),    32'(e.ex.v));
                chk("ex_ctrl",     32'(ex_ctrl),     32'(e.ex.ctrl));
                chk("bubble_cnt",  32'(bubble_cnt),  32'(e.ex.cnt));
                if (e.ex.data_known) begin
                    chk("ex_pc4",     ex_pc4,         e.ex.pc4);
                    chk("ex_rs_data", ex_rs_data,     e.ex.rsd);
                    chk("ex_rt_data", ex_rt_data,     e.ex.rtd);
                    chk("ex_imm",     ex_imm,         e.ex.imm);
                    chk("ex_rs",      32'(ex_rs),     32'(e.ex.rs));
                    chk("ex_rt",      32'(ex_rt),     32'(e.ex.rt));
                    chk("ex_wreg",    32'(ex_wreg),   32'(e.ex.wreg));
                end
            end
        end
    end

    localparam bit [11:0] C_ADDI = 12'h0E2;  // also used as the load in EX
    localparam bit [11:0] C_ORI  = 12'hA61;
    localparam bit [11:0] C_ADD  = 12'h126;  // RegDst: reads rt
    localparam bit [11:0] C_ADDI_NORT = 12'h0A2;

    // Driver: directed scenarios, random traffic, then counter saturation
    initial begin
        stim_t s;
        model = zero_ex();
        rst_n = 1'b0;
        cur = mk(1, 12'hFFF, 16'hFFFF, 5'd31, 5'd31, 5'd31, 0);
        apply(cur);
        repeat (3) drive_cycle(cur, 0);
        rst_n = 1'b1;

        // Sign- and zero-extended immediates
        drive_cycle(mk(1, C_ADDI, 16'h8001, 5'd1, 5'd5, 5'd9, 0), 0);
        drive_cycle(mk(1, C_ORI,  16'h8001, 5'd2, 5'd6, 5'd7, 0), 0);
        drive_cycle(mk(1, C_ADD,  16'h1234, 5'd2, 5'd6, 5'd7, 0), 0);

        // Load-use: lw rt=8 then add rs=8, add held for one cycle
        drive_cycle(mk(1, C_ADDI, 16'h0004, 5'd1, 5'd8, 5'd0, 0), 0);
        s = mk(1, C_ADD, 16'h0000, 5'd8, 5'd2, 5'd3, 0);
        drive_cycle(s, 0);
        drive_cycle(s, 0);
        drive_cycle(mk(0, 12'h000, 16'h0000, 5'd0, 5'd0, 5'd0, 0), 0);

        // No hazard: rt not read; load to r0
        drive_cycle(mk(1, C_ADDI, 16'h0004, 5'd1, 5'd8, 5'd0, 0), 0);
        drive_cycle(mk(1, C_ADDI_NORT, 16'h0010, 5'd3, 5'd8, 5'd0, 0), 0);
        drive_cycle(mk(1, C_ADDI, 16'h0004, 5'd1, 5'd0, 5'd0, 0), 0);
        drive_cycle(mk(1, C_ADD, 16'h0000, 5'd0, 5'd0, 5'd4, 0), 0);

        // Load-use together with flush: single bubble, no stall
        drive_cycle(mk(1, C_ADDI, 16'h0004, 5'd1, 5'd8, 5'd0, 0), 0);
        drive_cycle(mk(1, C_ADD, 16'h0000, 5'd8, 5'd2, 5'd3, 1), 0);
        drive_cycle(mk(1, C_ADD, 16'h0000, 5'd4, 5'd2, 5'd3, 0), 0);

        // Asynchronous reset mid-cycle while a valid instruction sits in EX
        drive_cycle(mk(1, C_ADD, 16'h0000, 5'd5, 5'd6, 5'd7, 0), 0);
        drive_cycle(mk(1, C_ADDI, 16'h8000, 5'd5, 5'd6, 5'd7, 0), 1);
        drive_cycle(mk(1, C_ADDI, 16'h8000, 5'd5, 5'd6, 5'd7, 0), 0);
        rst_n = 1'b1;

        // Random traffic with a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            if (last_stall && $urandom_range(0, 3) != 0) begin
                s = cur;
                s.flush = $urandom_range(0, 99) < 10;
            end else begin
                s = rnd_stim();
            end
            drive_cycle(s, 0);
        end

        // Saturation: continuous flushes of valid instructions
        drive_cycle(rnd_stim(), 1);
        drive_cycle(rnd_stim(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            s = rnd_stim();
            s.valid = 1'b1;
            s.flush = 1'b1;
            drive_cycle(s, 0);
        end
        drive_cycle(rnd_stim(), 0);
        drive_cycle(rnd_stim(), 1);
        drive_cycle(rnd_stim(), 0);
        rst_n = 1'b1;
        drive_cycle(rnd_stim(), 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
